// File: rtl/pr_pkg.sv
// Shared definitions for the response-time statistics block: default
// widths and the run-control FSM state encoding.
package pr_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DIVIDE  = 2'd2,
      DONE    = 2'd3
   } pr_state_e;

endpackage

// File: rtl/pr_seq_divider.sv
// Sequential restoring divider: unsigned ACC_W-bit dividend by CNT_W-bit
// divisor, one quotient bit per cycle.
// Timing: start_i loads the operands. ACC_W shift/subtract steps follow.
// done_o is then high for one cycle with quotient_o valid, so the result
// is captured ACC_W+1 clock edges after the load.
// A start_i during the done_o cycle reloads, which allows back-to-back
// divisions. A zero divisor returns a quotient of 0.
module pr_seq_divider #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8,
   parameter int Q_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [ACC_W-1:0] dividend_i,
   input  logic [CNT_W-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [Q_W-1:0]   quotient_o
);

   localparam int STEP_W = $clog2(ACC_W + 1);

   logic [ACC_W-1:0]  quo_q, quo_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  dsr_q;
   logic [STEP_W-1:0] step_q;
   logic              busy_q;
   logic              zero_q;
   logic [CNT_W:0]    trial;
   logic [CNT_W:0]    diff;
   logic              ge;

   // One restoring step: shift the next dividend bit into the remainder
   // and subtract the divisor when it fits.
   always_comb begin
      trial = {rem_q, quo_q[ACC_W-1]};
      diff  = trial - {1'b0, dsr_q};
      ge    = (trial >= {1'b0, dsr_q});
      rem_d = ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
      quo_d = {quo_q[ACC_W-2:0], ge};
   end

   // Operand load, step sequencing and completion.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         quo_q  <= '0;
         rem_q  <= '0;
         dsr_q  <= '0;
         step_q <= '0;
         busy_q <= 1'b0;
         zero_q <= 1'b0;
      end else if (start_i) begin
         quo_q  <= dividend_i;
         rem_q  <= '0;
         dsr_q  <= divisor_i;
         step_q <= STEP_W'(ACC_W);
         busy_q <= 1'b1;
         zero_q <= (divisor_i == '0);
      end else if (busy_q) begin
         if (step_q != '0) begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            step_q <= step_q - 1'b1;
         end else begin
            busy_q <= 1'b0;
         end
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = busy_q && (step_q == '0);
   assign quotient_o = zero_q ? '0 : quo_q[Q_W-1:0];

endmodule

// File: rtl/pr_result_stats.sv
// Response-time statistics collector.
// Collects N tester results and splits them into rise and fall sums and
// counts. It then divides each sum by its count with one shared divider.
// Build option PR_STATS_MINMAX_EN adds min/max tracking over the accepted
// samples. Without it, min_time and max_time read 0.
// Handshake: a result transfers on a rising clk edge where result_valid
// and result_ready are both 1. result_ready is 1 only in COLLECT.
// dbg_state exposes the FSM state for observation.
module pr_result_stats
   import pr_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  cfg_num_samples,
   input  logic              result_valid,
   output logic              result_ready,
   input  logic [DATA_W-1:0] result_data,
   input  logic              result_dir,
   output logic              busy,
   output logic              done,
   output logic              stats_valid,
   output logic [DATA_W-1:0] avg_rise,
   output logic [DATA_W-1:0] avg_fall,
   output logic [CNT_W-1:0]  cnt_rise,
   output logic [CNT_W-1:0]  cnt_fall,
   output logic [DATA_W-1:0] min_time,
   output logic [DATA_W-1:0] max_time,
   output pr_state_e         dbg_state
);

   localparam int ACC_W = DATA_W + CNT_W;

   pr_state_e         state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  cnt_tot_q, cnt_tot_d;
   logic [CNT_W-1:0]  cnt_rise_q, cnt_rise_d;
   logic [CNT_W-1:0]  cnt_fall_q, cnt_fall_d;
   logic [ACC_W-1:0]  sum_rise_q, sum_rise_d;
   logic [ACC_W-1:0]  sum_fall_q, sum_fall_d;
   logic [DATA_W-1:0] avg_rise_q, avg_rise_d;
   logic [DATA_W-1:0] avg_fall_q, avg_fall_d;
   logic              phase_q, phase_d;      // 0: rise division, 1: fall division
   logic              done_q, done_d;
   logic              stats_valid_q, stats_valid_d;

   logic              run_start;
   logic              take;
   logic              last;
   logic              div_start;
   logic [ACC_W-1:0]  div_dividend;
   logic [CNT_W-1:0]  div_divisor;
   logic              div_busy;
   logic              div_done;
   logic [DATA_W-1:0] div_quot;

   // Abort has priority over start. A zero sample count never starts a run.
   assign run_start = ((state_q == IDLE) || (state_q == DONE)) && start && !abort
                      && (cfg_num_samples != '0);
   assign take      = result_valid && result_ready && !abort;
   assign last      = take && (({1'b0, cnt_tot_q} + 1'b1) == {1'b0, n_q});

   // Next-state logic and datapath updates. The rise division is launched
   // on the Nth accept, from the sums that include that sample. The fall
   // division is launched in the cycle that the rise quotient is captured.
   always_comb begin
      state_d       = state_q;
      n_d           = n_q;
      cnt_tot_d     = cnt_tot_q;
      cnt_rise_d    = cnt_rise_q;
      cnt_fall_d    = cnt_fall_q;
      sum_rise_d    = sum_rise_q;
      sum_fall_d    = sum_fall_q;
      avg_rise_d    = avg_rise_q;
      avg_fall_d    = avg_fall_q;
      phase_d       = phase_q;
      done_d        = 1'b0;
      stats_valid_d = stats_valid_q;
      div_start     = 1'b0;
      div_dividend  = sum_rise_q;
      div_divisor   = cnt_rise_q;
      case (state_q)
         IDLE, DONE: begin
            if (run_start) begin
               n_d           = cfg_num_samples;
               cnt_tot_d     = '0;
               cnt_rise_d    = '0;
               cnt_fall_d    = '0;
               sum_rise_d    = '0;
               sum_fall_d    = '0;
               avg_rise_d    = '0;
               avg_fall_d    = '0;
               stats_valid_d = 1'b0;
               state_d       = COLLECT;
            end
         end
         COLLECT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (take) begin
               if (result_dir) begin
                  sum_fall_d = sum_fall_q + {{CNT_W{1'b0}}, result_data};
                  cnt_fall_d = cnt_fall_q + 1'b1;
               end else begin
                  sum_rise_d = sum_rise_q + {{CNT_W{1'b0}}, result_data};
                  cnt_rise_d = cnt_rise_q + 1'b1;
               end
               cnt_tot_d = cnt_tot_q + 1'b1;
               if (last) begin
                  state_d      = DIVIDE;
                  phase_d      = 1'b0;
                  div_start    = 1'b1;
                  div_dividend = sum_rise_d;
                  div_divisor  = cnt_rise_d;
               end
            end
         end
         DIVIDE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (div_busy && div_done) begin
               if (!phase_q) begin
                  avg_rise_d   = div_quot;
                  phase_d      = 1'b1;
                  div_start    = 1'b1;
                  div_dividend = sum_fall_q;
                  div_divisor  = cnt_fall_q;
               end else begin
                  avg_fall_d    = div_quot;
                  done_d        = 1'b1;
                  stats_valid_d = 1'b1;
                  state_d       = DONE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         n_q           <= '0;
         cnt_tot_q     <= '0;
         cnt_rise_q    <= '0;
         cnt_fall_q    <= '0;
         sum_rise_q    <= '0;
         sum_fall_q    <= '0;
         avg_rise_q    <= '0;
         avg_fall_q    <= '0;
         phase_q       <= 1'b0;
         done_q        <= 1'b0;
         stats_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         n_q           <= n_d;
         cnt_tot_q     <= cnt_tot_d;
         cnt_rise_q    <= cnt_rise_d;
         cnt_fall_q    <= cnt_fall_d;
         sum_rise_q    <= sum_rise_d;
         sum_fall_q    <= sum_fall_d;
         avg_rise_q    <= avg_rise_d;
         avg_fall_q    <= avg_fall_d;
         phase_q       <= phase_d;
         done_q        <= done_d;
         stats_valid_q <= stats_valid_d;
      end
   end

   pr_seq_divider #(
      .ACC_W (ACC_W),
      .CNT_W (CNT_W),
      .Q_W   (DATA_W)
   ) u_div (
      .clk_i      (clk),
      .rst_i      (reset),
      .start_i    (div_start),
      .dividend_i (div_dividend),
      .divisor_i  (div_divisor),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (div_quot)
   );

`ifdef PR_STATS_MINMAX_EN
   logic [DATA_W-1:0] min_q, max_q;

   // Track the unsigned extremes of the accepted samples in the current run.
   always_ff @(posedge clk) begin
      if (reset || run_start) begin
         min_q <= '1;
         max_q <= '0;
      end else if (take) begin
         if (result_data < min_q) min_q <= result_data;
         if (result_data > max_q) max_q <= result_data;
      end
   end

   assign min_time = min_q;
   assign max_time = max_q;
`else
   assign min_time = '0;
   assign max_time = '0;
`endif

   assign result_ready = (state_q == COLLECT);
   assign busy         = (state_q == COLLECT) || (state_q == DIVIDE);
   assign done         = done_q;
   assign stats_valid  = stats_valid_q;
   assign avg_rise     = avg_rise_q;
   assign avg_fall     = avg_fall_q;
   assign cnt_rise     = cnt_rise_q;
   assign cnt_fall     = cnt_fall_q;
   assign dbg_state    = state_q;

endmodule
